// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer: releases per-stage resets one at a time, gated on each stage's ready, with timeout fault
//   clk, rst_sys_n (async active-low power-on reset), sw_rst_req (1-cycle re-sequence request)
//   stage_ready[i] (stage i init finished), stage_rst_n[i] (active-low reset to stage i)
//   seq_busy, seq_done, timeout_err (sticky), fail_stage (index of timed-out stage)
module reset_release_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 256,
  parameter int STAGE_GAP   = 16,
  parameter int TIMEOUT     = 4096
) (
  input  logic                  clk,
  input  logic                  rst_sys_n,
  input  logic                  sw_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic                  timeout_err,
  output logic [2:0]            fail_stage
);
  localparam int HG = HOLD_CYCLES > STAGE_GAP ? HOLD_CYCLES : STAGE_GAP;
  localparam int MX = HG > TIMEOUT ? HG : TIMEOUT;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] TO_END   = CW'(TIMEOUT - 1);
  localparam logic [2:0]    LAST     = 3'(NUM_STAGES - 1);
  typedef enum logic [2:0] {HOLD, RELEASE, WAIT_RDY, GAP, DONE, FAULT} state_t;
  state_t                  state;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic [CW-1:0]           cnt;
  logic [2:0]              idx;
  logic [NUM_STAGES-1:0]   sel;
  logic                    rst_sync_n;
  logic                    rdy;
  assign rst_sync_n = sync_q[SYNC_STAGES-1];
  assign sel        = NUM_STAGES'(1) << idx;
  assign rdy        = |(stage_ready & sel);
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      sync_q      <= '0;
      state       <= HOLD;
      cnt         <= '0;
      idx         <= '0;
      stage_rst_n <= '0;
      seq_busy    <= 1'b1;
      seq_done    <= 1'b0;
      timeout_err <= 1'b0;
      fail_stage  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      if (!rst_sync_n) begin
        state <= HOLD;
        cnt   <= '0;
      end else if (sw_rst_req) begin
        state       <= HOLD;
        cnt         <= '0;
        idx         <= '0;
        stage_rst_n <= '0;
        seq_busy    <= 1'b1;
        seq_done    <= 1'b0;
        timeout_err <= 1'b0;
        fail_stage  <= '0;
      end else begin
        case (state)
          HOLD: begin
            state <= cnt == HOLD_END ? RELEASE : HOLD;
            cnt   <= cnt == HOLD_END ? '0 : cnt + CW'(1);
            idx   <= '0;
          end
          RELEASE: begin
            stage_rst_n <= stage_rst_n | sel;
            state       <= WAIT_RDY;
            cnt         <= '0;
          end
          WAIT_RDY: begin
            // ready takes precedence over a coincident timeout
            if (rdy) begin
              state    <= idx == LAST ? DONE : GAP;
              seq_done <= idx == LAST;
              seq_busy <= idx != LAST;
              cnt      <= '0;
            end else if (cnt == TO_END) begin
              state       <= FAULT;
              timeout_err <= 1'b1;
              fail_stage  <= idx;
              cnt         <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          GAP: begin
            state <= cnt == GAP_END ? RELEASE : GAP;
            idx   <= cnt == GAP_END ? idx + 3'd1 : idx;
            cnt   <= cnt == GAP_END ? '0 : cnt + CW'(1);
          end
          default: cnt <= '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_reset_release_sequencer.sv
// tb_reset_release_sequencer: scoreboard bench for the reset release sequencer
module tb_reset_release_sequencer;
  logic       clk = 1'b0;
  logic       rst_sys_n = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [2:0] stage_ready = 3'b111;
  logic [2:0] stage_rst_n;
  logic       seq_busy, seq_done, timeout_err;
  logic [2:0] fail_stage;
  typedef struct {
    int         cyc;
    logic [8:0] val;
    string      name;
  } exp_t;
  exp_t q[$];
  int   cyc = 0;
  int   base = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  event chk_now;
  reset_release_sequencer #(
    .NUM_STAGES(3), .SYNC_STAGES(2), .HOLD_CYCLES(8), .STAGE_GAP(4), .TIMEOUT(32)
  ) dut (
    .clk(clk), .rst_sys_n(rst_sys_n), .sw_rst_req(sw_rst_req), .stage_ready(stage_ready),
    .stage_rst_n(stage_rst_n), .seq_busy(seq_busy), .seq_done(seq_done),
    .timeout_err(timeout_err), .fail_stage(fail_stage)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(negedge clk or chk_now);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [8:0] got;
      e = q.pop_front();
      got = {stage_rst_n, seq_busy, seq_done, timeout_err, fail_stage};
      n_chk++;
      if (got !== e.val || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s edge %0d (at %0d): got rst=%b busy=%b done=%b err=%b fs=%0d, want rst=%b busy=%b done=%b err=%b fs=%0d",
                 e.name, e.cyc - base, cyc, got[8:6], got[5], got[4], got[3], got[2:0],
                 e.val[8:6], e.val[5], e.val[4], e.val[3], e.val[2:0]);
      end
    end
  end
  task automatic push(input int k, input logic [2:0] r, input logic b, input logic d,
                      input logic er, input logic [2:0] fs, input string nm);
    exp_t e;
    e.cyc = base + k;
    e.val = {r, b, d, er, fs};
    e.name = nm;
    q.push_back(e);
  endtask
  task automatic wait_to(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask
  task automatic sw_pulse_at(input int k);
    wait_to(k - 1);
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
  endtask
  task automatic por(input logic [2:0] rdy);
    @(negedge clk);
    rst_sys_n = 1'b0;
    stage_ready = rdy;
    base = cyc;
    push(1, 3'b000, 1, 0, 0, 3'd0, "por_hold");
    @(negedge clk);
    @(negedge clk);
    rst_sys_n = 1'b1;
    base = cyc;
  endtask
  initial begin
    por(3'b111);
    push(1,  3'b000, 1, 0, 0, 3'd0, "n_sync");
    push(10, 3'b000, 1, 0, 0, 3'd0, "n_pre_rel0");
    push(11, 3'b001, 1, 0, 0, 3'd0, "n_rel0");
    push(16, 3'b001, 1, 0, 0, 3'd0, "n_pre_rel1");
    push(17, 3'b011, 1, 0, 0, 3'd0, "n_rel1");
    push(22, 3'b011, 1, 0, 0, 3'd0, "n_pre_rel2");
    push(23, 3'b111, 1, 0, 0, 3'd0, "n_rel2");
    push(24, 3'b111, 0, 1, 0, 3'd0, "n_done");
    wait_to(26);
    base = cyc + 1;
    push(0,  3'b000, 1, 0, 0, 3'd0, "sw_clear");
    push(8,  3'b000, 1, 0, 0, 3'd0, "sw_pre_rel0");
    push(9,  3'b001, 1, 0, 0, 3'd0, "sw_rel0");
    push(15, 3'b011, 1, 0, 0, 3'd0, "sw_rel1");
    push(21, 3'b111, 1, 0, 0, 3'd0, "sw_rel2");
    push(22, 3'b111, 0, 1, 0, 3'd0, "sw_done");
    sw_pulse_at(0);
    wait_to(24);
    base = cyc + 1;
    push(0,  3'b000, 1, 0, 0, 3'd0, "coin_restart");
    push(21, 3'b111, 1, 0, 0, 3'd0, "coin_rel2");
    push(22, 3'b000, 1, 0, 0, 3'd0, "coin_sw_wins");
    push(31, 3'b001, 1, 0, 0, 3'd0, "coin_rel0_again");
    sw_pulse_at(0);
    sw_pulse_at(22);
    wait_to(32);
    por(3'b111);
    push(11, 3'b001, 1, 0, 0, 3'd0, "ad_rel0");
    wait_to(12);
    @(posedge clk);
    #2 rst_sys_n = 1'b0;
    #1;
    push(cyc - base, 3'b000, 1, 0, 0, 3'd0, "ad_async_clear");
    -> chk_now;
    @(negedge clk);
    @(negedge clk);
    rst_sys_n = 1'b1;
    base = cyc;
    push(10, 3'b000, 1, 0, 0, 3'd0, "ad_pre_rel0");
    push(11, 3'b001, 1, 0, 0, 3'd0, "ad_rel0_again");
    push(24, 3'b111, 0, 1, 0, 3'd0, "ad_done");
    wait_to(25);
    por(3'b101);
    push(11, 3'b001, 1, 0, 0, 3'd0, "to_rel0");
    push(17, 3'b011, 1, 0, 0, 3'd0, "to_rel1");
    push(48, 3'b011, 1, 0, 0, 3'd0, "to_pre_fault");
    push(49, 3'b011, 1, 0, 1, 3'd1, "to_fault");
    push(60, 3'b011, 1, 0, 1, 3'd1, "to_fault_hold");
    push(62, 3'b000, 1, 0, 0, 3'd0, "fx_clear");
    push(71, 3'b001, 1, 0, 0, 3'd0, "fx_rel0");
    push(84, 3'b111, 0, 1, 0, 3'd0, "fx_done");
    wait_to(61);
    stage_ready = 3'b111;
    sw_pulse_at(62);
    wait_to(86);
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations never checked, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
